snn_step_scheduler: RTL and testbench

- Timestep controller and round-robin event arbiter for a time-multiplexed IF neuron.
- Per run it pulses the neuron reset once. Each timestep it captures the input spike vector and serialises the set bits as indexed events into the shared weight-accumulate datapath. It then strobes threshold evaluation.
- Sits between the input spike encoder and the if_neuron accumulate/compare logic.

---
 rtl/snn_step_scheduler_pkg.sv | 16 +
 rtl/snn_step_scheduler_rr_arbiter.sv | 32 +++
 rtl/snn_step_scheduler.sv | 160 ++++++++++++++++
 tb/tb_snn_step_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_step_scheduler_pkg.sv
// Shared types for the SNN timestep scheduler: FSM state encoding and default sizes.
package snn_sched_pkg;

  localparam int DEF_NUM_INPUTS = 4;
  localparam int DEF_STEP_W     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    CAPTURE = 3'd2,
    ARB     = 3'd3,
    EVAL    = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/snn_step_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set pending bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] pending,
  input  logic [IDX_W-1:0]      ptr,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  int               pos;
  logic [IDX_W-1:0] sel;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    sel = '0;
    for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= NUM_INPUTS) pos = pos - NUM_INPUTS;
      sel = IDX_W'(pos);
      if (pending[sel]) begin
        idx = sel;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Timestep controller and round-robin event serialiser for a time-multiplexed IF neuron.
// Optional SNN_SPIKE_COUNT_EN adds a saturating output-spike counter per run.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | one-cycle neuron membrane reset
// CAPTURE | latch spike_in into pending
// ARB     | offer pending events one at a time
// EVAL    | one-cycle threshold evaluation strobe
// DONE    | one-cycle done pulse
module snn_step_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int STEP_W     = DEF_STEP_W,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [STEP_W-1:0]     num_steps,
  input  logic [NUM_INPUTS-1:0] spike_in,
  output logic                  ev_valid,
  output logic [IDX_W-1:0]      ev_idx,
  input  logic                  ev_ready,
  output logic                  neuron_rst,
  output logic                  eval_strobe,
  output logic [STEP_W-1:0]     step_idx,
  output logic                  busy,
  output logic                  done
`ifdef SNN_SPIKE_COUNT_EN
  ,
  input  logic                  neuron_spike,
  output logic [STEP_W-1:0]     spike_count
`endif
);

  state_t                  state, state_nx;
  logic [STEP_W-1:0]       num_steps_q;
  logic [NUM_INPUTS-1:0]   pending;
  logic [IDX_W-1:0]        rr_ptr;

  logic [NUM_INPUTS-1:0]   pending_left;
  logic [IDX_W-1:0]        ptr_after;
  logic [NUM_INPUTS-1:0]   arb_pending;
  logic [IDX_W-1:0]        arb_ptr;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    accept;
  logic                    last_step;

  assign accept       = (state == ARB) && ev_ready;
  assign pending_left = pending & ~(NUM_INPUTS'(1) << ev_idx);
  assign ptr_after    = (ev_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : ev_idx + IDX_W'(1);
  assign last_step    = (step_idx == num_steps_q - STEP_W'(1));

  // In CAPTURE search the fresh vector; in ARB look ahead past the event being accepted.
  assign arb_pending  = (state == CAPTURE) ? spike_in : pending_left;
  assign arb_ptr      = (state == CAPTURE) ? rr_ptr   : ptr_after;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_arb (
    .pending (arb_pending),
    .ptr     (arb_ptr),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = (num_steps_q == '0) ? DONE : CAPTURE;
      CAPTURE: state_nx = (spike_in == '0) ? EVAL : ARB;
      ARB:     if (accept && !arb_any) state_nx = EVAL;
      EVAL:    state_nx = last_step ? DONE : CAPTURE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ev_valid    = 1'b0;
    neuron_rst  = 1'b0;
    eval_strobe = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (state)
      CLEAR: begin
        neuron_rst = 1'b1;
        busy       = 1'b1;
      end
      CAPTURE: busy = 1'b1;
      ARB: begin
        ev_valid = 1'b1;
        busy     = 1'b1;
      end
      EVAL: begin
        eval_strobe = 1'b1;
        busy        = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_steps_q <= '0;
      step_idx    <= '0;
      pending     <= '0;
      rr_ptr      <= '0;
      ev_idx      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          num_steps_q <= num_steps;
          step_idx    <= '0;
        end
        CAPTURE: begin
          pending <= spike_in;
          if (arb_any) ev_idx <= arb_idx;
        end
        ARB: if (ev_ready) begin
          pending <= pending_left;
          rr_ptr  <= ptr_after;
          if (arb_any) ev_idx <= arb_idx;
        end
        EVAL: if (!last_step) step_idx <= step_idx + STEP_W'(1);
        default: ;
      endcase
    end
  end

`ifdef SNN_SPIKE_COUNT_EN
  logic eval_q;

  // The neuron answers one cycle after the strobe, so the count follows a delayed strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_q      <= 1'b0;
      spike_count <= '0;
    end else begin
      eval_q <= (state == EVAL);
      if (state == CLEAR)
        spike_count <= '0;
      else if (eval_q && neuron_spike && (spike_count != '1))
        spike_count <= spike_count + STEP_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Scoreboard bench for snn_step_scheduler: driver queues expected events, negedge monitor checks them.
module tb_snn_step_scheduler;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic [N-1:0]  spike_in = '0;
  logic          ev_ready = 1'b1;
  logic          neuron_spike = 1'b0;
  logic          ev_valid;
  logic [IW-1:0] ev_idx;
  logic          neuron_rst;
  logic          eval_strobe;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          done;
`ifdef SNN_SPIKE_COUNT_EN
  logic [SW-1:0] spike_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_ev[$];
  int rst_cnt = 0, eval_cnt = 0, done_cnt = 0, acc_cnt = 0, stall_seen = 0, stall_cnt = 0;
  bit eval_last = 1'b0;
  logic [7:0] ns_mask = '0;
  logic [N-1:0] sp_tab[8];
  int ev_tab[8][4];

  snn_step_scheduler #(.NUM_INPUTS(N), .STEP_W(SW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_steps   (num_steps),
    .spike_in    (spike_in),
    .ev_valid    (ev_valid),
    .ev_idx      (ev_idx),
    .ev_ready    (ev_ready),
    .neuron_rst  (neuron_rst),
    .eval_strobe (eval_strobe),
    .step_idx    (step_idx),
    .busy        (busy),
    .done        (done)
`ifdef SNN_SPIKE_COUNT_EN
    ,
    .neuron_spike(neuron_spike),
    .spike_count (spike_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes the scoreboard and counts pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (neuron_rst) rst_cnt++;
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
        check("events_left_at_done", exp_ev.size(), 0);
      end
      if (eval_strobe) begin
        eval_cnt++;
        check("events_left_at_eval", exp_ev.size(), 0);
      end
      if (ev_valid) begin
        if (exp_ev.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev_unexpected: got idx %0d, expected no event", ev_idx);
        end else if (ev_ready) begin
          acc_cnt++;
          check("ev_idx", ev_idx, exp_ev.pop_front());
        end else begin
          stall_seen++;
          check("ev_idx_held", ev_idx, exp_ev[0]);
        end
      end
      eval_last = eval_strobe;
    end
  end

  always @(posedge clk) begin
    #2;
    if (ev_valid && stall_cnt > 0) begin
      ev_ready = 1'b0;
      stall_cnt--;
    end else begin
      ev_ready = 1'b1;
    end
    neuron_spike = eval_last && (eval_cnt > 0) && ns_mask[3'(eval_cnt - 1)];
  end

  task automatic set_step(input int s, input logic [N-1:0] sp, input int e0, input int e1,
                          input int e2, input int e3);
    sp_tab[s]    = sp;
    ev_tab[s][0] = e0;
    ev_tab[s][1] = e1;
    ev_tab[s][2] = e2;
    ev_tab[s][3] = e3;
  endtask

  // which: 0 = eval_strobe, 1 = done, 2 = ev_valid
  task automatic wait_sig(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if ((which == 0 && eval_strobe) || (which == 1 && done) || (which == 2 && ev_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no event within 200 cycles, expected one", name);
    end
  endtask

  task automatic run_case(input string name, input int n, input int ev_tot, input int stall_cycles,
                          input bit poke_start, input int exp_sc);
    bit ok;
    int fin;
    exp_ev.delete();
    rst_cnt = 0; eval_cnt = 0; done_cnt = 0; acc_cnt = 0; stall_seen = 0;
    stall_cnt = stall_cycles;
    fin = (n == 0) ? 0 : n - 1;
    @(negedge clk); #1;
    num_steps = SW'(n);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check({name, "_rst_latency"}, neuron_rst, 1);
    check({name, "_busy"}, busy, 1);
    ok = 1'b1;
    for (int s = 0; s < n && ok; s++) begin
      if (s > 0) begin
        wait_sig(0, name, ok);
        if (poke_start && s == 1) begin
          start = 1'b1;
          num_steps = SW'(7);
        end
      end
      spike_in = sp_tab[s];
      for (int e = 0; e < 4; e++)
        if (ev_tab[s][e] >= 0) exp_ev.push_back(ev_tab[s][e]);
    end
    wait_sig(1, name, ok);
    if (ok) check({name, "_step_at_done"}, step_idx, fin);
    repeat (2) @(negedge clk);
    #1;
    check({name, "_neuron_rst_cnt"}, rst_cnt, 1);
    check({name, "_eval_cnt"}, eval_cnt, n);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_events"}, acc_cnt, ev_tot);
    check({name, "_stalls"}, stall_seen, stall_cycles);
    check({name, "_step_hold"}, step_idx, fin);
    check({name, "_idle_busy"}, busy, 0);
`ifdef SNN_SPIKE_COUNT_EN
    check({name, "_spike_count"}, spike_count, exp_sc);
`else
    if (exp_sc < 0) $display("note: negative spike count expectation ignored");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ev_valid", ev_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_step_idx", step_idx, 0);
    check("reset_neuron_rst", neuron_rst, 0);
    check("reset_eval", eval_strobe, 0);
    rst_n = 1'b1;

    // Sequential single spikes; rr pointer walks 0..3 and wraps to 0.
    set_step(0, 4'b0001, 0, -1, -1, -1);
    set_step(1, 4'b0010, 1, -1, -1, -1);
    set_step(2, 4'b0100, 2, -1, -1, -1);
    set_step(3, 4'b1000, 3, -1, -1, -1);
    run_case("seq", 4, 4, 0, 1'b0, 0);

    // All spikes from rr=0, then 0101 from rr=0; leaves rr=3.
    set_step(0, 4'b1111, 0, 1, 2, 3);
    set_step(1, 4'b0101, 0, 2, -1, -1);
    run_case("rr", 2, 6, 0, 1'b0, 0);

    // Backpressure from rr=3 on 0110: idx 1 held for 3 stalls, then 2; leaves rr=3.
    set_step(0, 4'b0110, 1, 2, -1, -1);
    run_case("bp", 1, 2, 3, 1'b0, 0);

    run_case("zero", 0, 0, 0, 1'b0, 0);

`ifdef SNN_SPIKE_COUNT_EN
    set_step(0, 4'b0000, -1, -1, -1, -1);
    set_step(1, 4'b0000, -1, -1, -1, -1);
    set_step(2, 4'b0000, -1, -1, -1, -1);
    set_step(3, 4'b0000, -1, -1, -1, -1);
    ns_mask = 8'b0000_0101;
    run_case("cnt", 4, 0, 0, 1'b0, 2);
    ns_mask = '0;
`endif

    // No spikes: evaluation only; spike counter must have been cleared.
    set_step(0, 4'b0000, -1, -1, -1, -1);
    set_step(1, 4'b0000, -1, -1, -1, -1);
    run_case("quiet", 2, 0, 0, 1'b0, 0);

    // Start pulsed mid-run with a different length must be ignored; rr=3 -> idx 3, then 0.
    set_step(0, 4'b1000, 3, -1, -1, -1);
    set_step(1, 4'b0001, 0, -1, -1, -1);
    set_step(2, 4'b0000, -1, -1, -1, -1);
    run_case("busy_start", 3, 2, 0, 1'b1, 0);

    // Reset while stalled in ARB with pending 1010 (rr=1 -> idx 1).
    exp_ev.delete();
    stall_cnt = 1000;
    done_cnt = 0;
    @(negedge clk); #1;
    num_steps = SW'(1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    spike_in = 4'b1010;
    exp_ev.push_back(1);
    wait_sig(2, "rst_arb", ok);
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_ev_valid", ev_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arb_rst_ev_valid", ev_valid, 0);
    check("arb_rst_busy", busy, 0);
    check("arb_rst_done", done, 0);
    check("arb_rst_eval", eval_strobe, 0);
    check("arb_rst_neuron_rst", neuron_rst, 0);
    check("arb_rst_step_idx", step_idx, 0);
    check("arb_rst_ev_idx", ev_idx, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    stall_cnt = 0;
    exp_ev.delete();
    repeat (3) @(negedge clk);
    #1;
    check("arb_rst_no_done", done_cnt, 0);
    check("arb_rst_idle_busy", busy, 0);

    // Normal run after reset: rr back to 0.
    set_step(0, 4'b1100, 2, 3, -1, -1);
    set_step(1, 4'b0011, 0, 1, -1, -1);
    run_case("after_rst", 2, 4, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
